// File: rtl/gate_vector_checker.sv
// gate_vector_checker: accepts (a, b, y) vectors from the gate bank and
// recomputes the seven expected gate outputs from a and b. Over a run of
// NUM_VECTORS vectors it counts accepted vectors and mismatches, records the
// first failing vector, and ends with a sticky done/pass verdict.
module gate_vector_checker #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [1:0]       first_fail_ab,
  output logic [6:0]       first_fail_y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_VECTORS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [1:0]       first_fail_ab_q, first_fail_ab_d;
  logic [6:0]       first_fail_y_q, first_fail_y_d;

  logic [6:0]       exp_y;
  logic             mismatch;
  logic             accept;
  logic [CNT_W-1:0] vec_count_inc;

  // Expected gate outputs and per-vector comparison; X/Z on y counts as a mismatch
  always_comb begin
    exp_y         = {a & b, a | b, ~b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    mismatch      = (y !== exp_y);
    accept        = in_valid && (state_q == S_RUN);
    vec_count_inc = vec_count_q + 1'b1;
  end

  // Next-state and result-register update logic
  always_comb begin
    state_d          = state_q;
    vec_count_d      = vec_count_q;
    err_count_d      = err_count_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_ab_d  = first_fail_ab_q;
    first_fail_y_d   = first_fail_y_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_RUN;
          vec_count_d      = '0;
          err_count_d      = '0;
          first_fail_idx_d = '0;
          first_fail_ab_d  = '0;
          first_fail_y_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          vec_count_d = vec_count_inc;
          if (mismatch) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (err_count_q == '0) begin
              first_fail_idx_d = vec_count_q;
              first_fail_ab_d  = {a, b};
              first_fail_y_d   = y;
            end
          end
          if (vec_count_inc == LAST_COUNT) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      vec_count_q      <= '0;
      err_count_q      <= '0;
      first_fail_idx_q <= '0;
      first_fail_ab_q  <= '0;
      first_fail_y_q   <= '0;
    end else begin
      state_q          <= state_d;
      vec_count_q      <= vec_count_d;
      err_count_q      <= err_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_ab_q  <= first_fail_ab_d;
      first_fail_y_q   <= first_fail_y_d;
    end
  end

  // Status outputs depend on state only; pass is qualified by done
  always_comb begin
    in_ready       = (state_q == S_RUN);
    busy           = (state_q == S_RUN);
    done           = (state_q == S_DONE);
    pass           = (state_q == S_DONE) && (err_count_q == '0);
    vec_count      = vec_count_q;
    err_count      = err_count_q;
    first_fail_idx = first_fail_idx_q;
    first_fail_ab  = first_fail_ab_q;
    first_fail_y   = first_fail_y_q;
  end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Downstream consumer of the two-input behavioural gate bank. It accepts one (a, b, y[6:0]) vector per handshake, recomputes the expected seven gate outputs from a and b, and compares them bit-for-bit. Over a run of NUM_VECTORS vectors it counts accepted vectors and mismatches, and records the first failing vector. It ends each run with a sticky done/pass verdict that top-level self-check logic can read.

## Interface
- NUM_VECTORS, default 4: vectors per run; must be ≥ 1 and ≤ 2^CNT_W − 1.
- CNT_W, default 8: width of the vector and error counters.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a run; sampled in IDLE and DONE only.
- in_valid  input  1  a, b and y are valid this cycle.
- in_ready  output  1  checker accepts a vector this cycle.
- a, b  input  1 each  gate inputs as applied to the gate bank.
- y  input  7  gate outputs: [6]=and, [5]=or, [4]=not b, [3]=nand, [2]=nor, [1]=xor, [0]=xnor.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; sticky until the next start or reset.
- pass  output  1  meaningful only while done=1: 1 iff err_count==0.
- vec_count  output  CNT_W  vectors accepted in the current run.
- err_count  output  CNT_W  mismatching vectors in the current run; saturates at all-ones.
- first_fail_idx  output  CNT_W  vec_count value at the first mismatch.
- first_fail_ab  output  2  {a,b} of the first mismatch.
- first_fail_y  output  7  y of the first mismatch.

## Operation
- The FSM has three states: IDLE, RUN, DONE. On reset it enters IDLE.
- IDLE
  - in_ready=0.
  - start=1 moves to RUN and clears vec_count, err_count and the first_fail_* fields to 0.
- RUN
  - in_ready=1 and busy=1.
  - A vector is accepted on any edge where in_valid && in_ready.
  - start is ignored.
- DONE
  - in_ready=0 and done=1.
  - start=1 moves to RUN with the same clears as from IDLE. done drops at that edge.
- Expected outputs are computed from a and b: {a&b, a|b, ~b, ~(a&b), ~(a|b), a^b, ~(a^b)}.
- A mismatch is any y bit that differs from its expected bit. In simulation, an X or Z on any y bit also counts as a mismatch (case-inequality semantics).
- On each accepted vector:
  - vec_count increments by 1.
  - On a mismatch, err_count increments unless it is already all-ones.
  - On the first mismatch of the run (err_count was 0), first_fail_idx takes the pre-increment vec_count, and first_fail_ab and first_fail_y capture the vector.
- When the accept takes vec_count to NUM_VECTORS, the FSM moves to DONE on that same edge.
- Idle cycles with in_valid=0 in RUN change nothing.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, pass=0, and every counter and first_fail_* field = 0.
- The comparison is combinational on the accept cycle. All result registers update on that accept edge and are visible in the following cycle.
- Latency: done=1 and pass are valid in the cycle immediately after the edge that accepts the last vector.
- in_ready is a function of state only and does not depend combinationally on in_valid.
- The producer may hold in_valid high continuously; back-to-back vectors are accepted at one per cycle.
- If rst_n is asserted mid-run, all outputs return to their reset values immediately. No partial result is retained.
- start and an accept cannot coincide, because start is ignored in RUN.

## Test plan
- Run with the 4 correct vectors. Stimulus: start, then (a,b,y) = (0,0,0011101), (0,1,0101010), (1,0,0111010), (1,1,1100001). Required: done=1, pass=1, vec_count=4, err_count=0, first_fail_* = 0.
- Same run, but the third vector is (1,0,0111011). Required: err_count=1, pass=0, first_fail_idx=2, first_fail_ab=10, first_fail_y=0111011.
- Same correct run with in_valid low on alternate cycles. Required: vec_count advances only on valid cycles, and done rises exactly one cycle after the 4th accept.
- CNT_W=2, NUM_VECTORS=3, all vectors wrong. Required: err_count=3 with no wrap. Then NUM_VECTORS=2 with both wrong: err_count=2, first_fail_idx=0.
- Drive rst_n low after 2 accepts. Required: all outputs at reset values and state IDLE. A new start then completes a clean 4-vector pass.
- After a failing run, pulse start while in DONE. Required: counters and first_fail_* clear, done drops, and a following correct run gives pass=1.
